// File: rtl/ncsu_regfile_mp_if.sv
// Bus bundle for the two-read/one-write register file: write port, two read
// ports and the clear/busy handshake of the array sweeper.
interface ncsu_regfile_mp_if #(
    parameter int WIDTH        = 16,
    parameter int ADDRESSWIDTH = 5
);
    logic                    write_en;
    logic [ADDRESSWIDTH-1:0] dest;
    logic [WIDTH-1:0]        data_in;
    logic                    read_en_a;
    logic [ADDRESSWIDTH-1:0] source_a;
    logic [WIDTH-1:0]        data_out_a;
    logic                    read_en_b;
    logic [ADDRESSWIDTH-1:0] source_b;
    logic [WIDTH-1:0]        data_out_b;
    logic                    clear;
    logic                    busy;

    modport master (
        output write_en, dest, data_in,
        output read_en_a, source_a, read_en_b, source_b,
        output clear,
        input  data_out_a, data_out_b, busy
    );

    modport slave (
        input  write_en, dest, data_in,
        input  read_en_a, source_a, read_en_b, source_b,
        input  clear,
        output data_out_a, data_out_b, busy
    );
endinterface

// File: rtl/ncsu_regfile_mp.sv
// Register file with one write port, two registered read ports and a DEPTH-cycle
// clear sweeper. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module ncsu_regfile_mp #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 32,
    parameter int ADDRESSWIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ncsu_regfile_mp_if.slave      rf_io
);
    localparam logic [ADDRESSWIDTH:0]   DEPTH_W  = (ADDRESSWIDTH+1)'(DEPTH);
    localparam logic [ADDRESSWIDTH-1:0] LAST_PTR = ADDRESSWIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] clr_ptr_q, clr_ptr_d;
    logic                    busy;
    logic                    wr_acc;

    // Flop-based storage: the asynchronous reset has to zero every entry at once.
    logic [WIDTH-1:0]        rf_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            IDLE: begin
                if (rf_io.clear) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                clr_ptr_d = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == CLEAR);
    end

    assign rf_io.busy = busy;
    assign wr_acc     = rf_io.write_en & ~busy & ({1'b0, rf_io.dest} < DEPTH_W);

    // Sweep and accepted writes are mutually exclusive because busy blocks writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (busy) begin
            rf_q[clr_ptr_q] <= '0;
        end else if (wr_acc) begin
            rf_q[rf_io.dest] <= rf_io.data_in;
        end
    end

    logic                    rd_en   [2];
    logic [ADDRESSWIDTH-1:0] rd_src  [2];
    logic [WIDTH-1:0]        rd_data [2];

    assign rd_en[0]  = rf_io.read_en_a;
    assign rd_en[1]  = rf_io.read_en_b;
    assign rd_src[0] = rf_io.source_a;
    assign rd_src[1] = rf_io.source_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        logic             src_ok;
        logic [WIDTH-1:0] rd_d, rd_q;

        assign src_ok = ({1'b0, rd_src[gi]} < DEPTH_W);

        always_comb begin
            rd_d = rd_q;
            if (rd_en[gi]) begin
                if (!src_ok) begin
                    rd_d = '0;
`ifdef REGFILE_BYPASS_EN
                end else if (wr_acc && (rf_io.dest == rd_src[gi])) begin
                    rd_d = rf_io.data_in;
`endif
                end else begin
                    rd_d = rf_q[rd_src[gi]];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd_data[gi] = rd_q;
    end

    assign rf_io.data_out_a = rd_data[0];
    assign rf_io.data_out_b = rd_data[1];
endmodule

// File: tb/tb_ncsu_regfile_mp.sv
// Directed bench for ncsu_regfile_mp: a 32-entry and a 20-entry instance share
// clock and reset; expected values are hand-derived per scenario.
module tb_ncsu_regfile_mp;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ncsu_regfile_mp_if #(.WIDTH(16), .ADDRESSWIDTH(5)) bus ();
    ncsu_regfile_mp_if #(.WIDTH(16), .ADDRESSWIDTH(5)) bus20 ();

    ncsu_regfile_mp #(.WIDTH(16), .DEPTH(32), .ADDRESSWIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf_io (bus)
    );

    ncsu_regfile_mp #(.WIDTH(16), .DEPTH(20), .ADDRESSWIDTH(5)) dut20 (
        .clk   (clk),
        .rst_n (rst_n),
        .rf_io (bus20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.write_en   = 1'b0; bus.dest     = '0; bus.data_in  = '0;
        bus.read_en_a  = 1'b0; bus.source_a = '0;
        bus.read_en_b  = 1'b0; bus.source_b = '0;
        bus.clear      = 1'b0;
        bus20.write_en = 1'b0; bus20.dest     = '0; bus20.data_in = '0;
        bus20.read_en_a = 1'b0; bus20.source_a = '0;
        bus20.read_en_b = 1'b0; bus20.source_b = '0;
        bus20.clear    = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [15:0] data);
        bus.write_en = 1'b1; bus.dest = addr; bus.data_in = data;
        cyc();
        bus.write_en = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b);
        bus.read_en_a = 1'b1; bus.source_a = a;
        bus.read_en_b = 1'b1; bus.source_b = b;
        cyc();
        bus.read_en_a = 1'b0; bus.read_en_b = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) cyc();
        n_checks++; if (bus.data_out_a !== 16'h0) begin n_fail++; $display("FAIL reset_dout_a: got %h want 0000", bus.data_out_a); end
        n_checks++; if (bus.data_out_b !== 16'h0) begin n_fail++; $display("FAIL reset_dout_b: got %h want 0000", bus.data_out_b); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        cyc();
        $display("test_reset: dout_a=%h dout_b=%h busy=%b", bus.data_out_a, bus.data_out_b, bus.busy);
    endtask

    task automatic test_dual_read();
        do_write(5'd3, 16'h1234);
        do_write(5'd31, 16'hBEEF);
        do_read(5'd3, 5'd31);
        n_checks++; if (bus.data_out_a !== 16'h1234) begin n_fail++; $display("FAIL dual_read_a: got %h want 1234", bus.data_out_a); end
        n_checks++; if (bus.data_out_b !== 16'hBEEF) begin n_fail++; $display("FAIL dual_read_b: got %h want beef", bus.data_out_b); end
        do_read(5'd3, 5'd3);
        n_checks++; if (bus.data_out_a !== 16'h1234 || bus.data_out_b !== 16'h1234) begin
            n_fail++; $display("FAIL same_addr: got a=%h b=%h want 1234/1234", bus.data_out_a, bus.data_out_b);
        end
        $display("test_dual_read: a=%h b=%h", bus.data_out_a, bus.data_out_b);
    endtask

    task automatic test_bypass();
        logic [15:0] exp_first;
`ifdef REGFILE_BYPASS_EN
        exp_first = 16'hA5A5;
`else
        exp_first = 16'h0001;
`endif
        do_write(5'd7, 16'h0001);
        bus.write_en  = 1'b1; bus.dest = 5'd7; bus.data_in = 16'hA5A5;
        bus.read_en_a = 1'b1; bus.source_a = 5'd7;
        cyc();
        bus.write_en = 1'b0;
        n_checks++; if (bus.data_out_a !== exp_first) begin n_fail++; $display("FAIL bypass_same_cycle: got %h want %h", bus.data_out_a, exp_first); end
        cyc();
        bus.read_en_a = 1'b0;
        n_checks++; if (bus.data_out_a !== 16'hA5A5) begin n_fail++; $display("FAIL bypass_next_read: got %h want a5a5", bus.data_out_a); end
        $display("test_bypass: dout_a=%h", bus.data_out_a);
    endtask

    task automatic test_hold_b();
        logic [4:0] srcs [4];
        srcs[0] = 5'd3; srcs[1] = 5'd7; srcs[2] = 5'd31; srcs[3] = 5'd0;
        do_read(5'd0, 5'd31);
        for (int i = 0; i < 4; i++) begin
            bus.read_en_b = 1'b0; bus.source_b = srcs[i];
            bus.write_en  = 1'b1; bus.dest = srcs[i]; bus.data_in = 16'h1000 + 16'(i);
            cyc();
            n_checks++; if (bus.data_out_b !== 16'hBEEF) begin n_fail++; $display("FAIL hold_b[%0d]: got %h want beef", i, bus.data_out_b); end
            $display("test_hold_b[%0d]: src=%0d dout_b=%h", i, srcs[i], bus.data_out_b);
        end
        bus.write_en = 1'b0;
    endtask

    task automatic test_clear();
        int n_busy;
        for (int i = 0; i < 32; i++) do_write(5'(i), 16'h0100 + 16'(i));
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        n_busy = 0;
        while (bus.busy === 1'b1 && n_busy < 100) begin
            n_busy++;
            bus.write_en  = (n_busy == 3);
            bus.dest      = 5'd5;
            bus.data_in   = 16'hDEAD;
            bus.clear     = (n_busy == 10);
            bus.read_en_a = (n_busy == 5);
            bus.source_a  = 5'd20;
            cyc();
            if (n_busy == 5) begin
                n_checks++; if (bus.data_out_a !== 16'h0114) begin n_fail++; $display("FAIL read_during_sweep: got %h want 0114", bus.data_out_a); end
            end
        end
        idle_inputs();
        n_checks++; if (n_busy !== 32) begin n_fail++; $display("FAIL busy_cycles: got %0d want 32", n_busy); end
        $display("test_clear: busy cycles=%0d", n_busy);
        do_write(5'd9, 16'h0999);
        do_read(5'd5, 5'd31);
        n_checks++; if (bus.data_out_a !== 16'h0) begin n_fail++; $display("FAIL dropped_write: got %h want 0000", bus.data_out_a); end
        n_checks++; if (bus.data_out_b !== 16'h0) begin n_fail++; $display("FAIL cleared_last: got %h want 0000", bus.data_out_b); end
        do_read(5'd9, 5'd0);
        n_checks++; if (bus.data_out_a !== 16'h0999) begin n_fail++; $display("FAIL write_after_busy: got %h want 0999", bus.data_out_a); end
        n_checks++; if (bus.data_out_b !== 16'h0) begin n_fail++; $display("FAIL cleared_first: got %h want 0000", bus.data_out_b); end
        $display("test_clear: post-sweep e9=%h e0=%h", bus.data_out_a, bus.data_out_b);
    endtask

    task automatic test_out_of_range();
        bus20.write_en = 1'b1; bus20.dest = 5'd19; bus20.data_in = 16'h1919;
        cyc();
        bus20.dest = 5'd25; bus20.data_in = 16'hFFFF;
        bus20.read_en_a = 1'b1; bus20.source_a = 5'd25;
        cyc();
        bus20.write_en = 1'b0;
        n_checks++; if (bus20.data_out_a !== 16'h0) begin n_fail++; $display("FAIL oor_read: got %h want 0000", bus20.data_out_a); end
        bus20.read_en_b = 1'b1; bus20.source_b = 5'd19;
        bus20.source_a = 5'd5;
        cyc();
        n_checks++; if (bus20.data_out_b !== 16'h1919) begin n_fail++; $display("FAIL oor_last_entry: got %h want 1919", bus20.data_out_b); end
        n_checks++; if (bus20.data_out_a !== 16'h0) begin n_fail++; $display("FAIL oor_no_alias: got %h want 0000", bus20.data_out_a); end
        bus20.source_a = 5'd25;
        cyc();
        bus20.read_en_a = 1'b0; bus20.read_en_b = 1'b0;
        n_checks++; if (bus20.data_out_a !== 16'h0) begin n_fail++; $display("FAIL oor_reread: got %h want 0000", bus20.data_out_a); end
        $display("test_out_of_range: a=%h b=%h", bus20.data_out_a, bus20.data_out_b);
    endtask

    task automatic test_reset_mid_sweep();
        do_write(5'd15, 16'h0F0F);
        do_write(5'd31, 16'h3131);
        do_read(5'd31, 5'd15);
        n_checks++; if (bus.data_out_a !== 16'h3131) begin n_fail++; $display("FAIL pre_reset_read: got %h want 3131", bus.data_out_a); end
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        repeat (10) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.data_out_a !== 16'h0 || bus.data_out_b !== 16'h0) begin
            n_fail++; $display("FAIL async_reset_outs: got a=%h b=%h want 0000/0000", bus.data_out_a, bus.data_out_b);
        end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", bus.busy); end
        n_checks++; if (dut.rf_q[15] !== 16'h0 || dut.rf_q[31] !== 16'h0) begin
            n_fail++; $display("FAIL async_reset_array: got e15=%h e31=%h want 0000/0000", dut.rf_q[15], dut.rf_q[31]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        do_read(5'd15, 5'd31);
        n_checks++; if (bus.data_out_a !== 16'h0 || bus.data_out_b !== 16'h0) begin
            n_fail++; $display("FAIL post_reset_read: got a=%h b=%h want 0000/0000", bus.data_out_a, bus.data_out_b);
        end
        $display("test_reset_mid_sweep: a=%h b=%h busy=%b", bus.data_out_a, bus.data_out_b, bus.busy);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        test_reset();
        test_dual_read();
        test_bypass();
        test_hold_b();
        test_clear();
        test_out_of_range();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
